// File: rtl/writeback_queue.sv
// writeback_queue: in-order write-back buffer in front of the 32x32 register file.
// Accepts register writes over a valid/ready handshake, drains at most one entry
// per cycle onto the single register-file write port, and forwards the youngest
// queued value for two read indices.
//
// Ports:
//   clk, rstn                       clock, asynchronous active-low reset
//   in_valid/in_addr/in_data        producer write request
//   in_ready                        queue accepts this cycle (also while draining a full queue)
//   wb_stall                        hold the head entry this cycle
//   wb_wen/wb_addr/wb_data          register-file write port (zero when idle)
//   fwd_addr1/2                     lookup indices (tie to register-file read indices)
//   fwd_hit1/2, fwd_data1/2         youngest queued match for each lookup
//   count                           occupied entries
//
// Build option: define WBQ_FORWARD_EN to build the forwarding comparators;
// without it fwd_hit*/fwd_data* are tied to zero.
module writeback_queue #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    input  logic [ADDR_WIDTH-1:0]   in_addr,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ready,
    input  logic                    wb_stall,
    output logic                    wb_wen,
    output logic [ADDR_WIDTH-1:0]   wb_addr,
    output logic [DATA_WIDTH-1:0]   wb_data,
    input  logic [ADDR_WIDTH-1:0]   fwd_addr1,
    input  logic [ADDR_WIDTH-1:0]   fwd_addr2,
    output logic                    fwd_hit1,
    output logic                    fwd_hit2,
    output logic [DATA_WIDTH-1:0]   fwd_data1,
    output logic [DATA_WIDTH-1:0]   fwd_data2,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic deq;
    logic enq;

    // Handshake and head presentation
    assign deq      = (count_q != '0) && !wb_stall;
    assign in_ready = (count_q < CNT_W'(DEPTH)) || deq;
    // x0 writes complete the handshake but never occupy an entry
    assign enq      = in_valid && in_ready && (in_addr != '0);

    assign wb_wen  = deq;
    assign wb_addr = deq ? addr_q[rd_ptr_q] : '0;
    assign wb_data = deq ? data_q[rd_ptr_q] : '0;
    assign count   = count_q;

    // Next-state for pointers and occupancy
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (enq) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (enq && !deq) begin
            count_d = count_q + CNT_W'(1);
        end else if (!enq && deq) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state; entry storage is intentionally left uncleared by reset
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (enq) begin
            addr_q[wr_ptr_q] <= in_addr;
            data_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef WBQ_FORWARD_EN
    // Walk entries oldest to youngest so the last match wins
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) < count_q) begin
                if ((fwd_addr1 != '0) && (addr_q[rd_ptr_q + PTR_W'(i)] == fwd_addr1)) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = data_q[rd_ptr_q + PTR_W'(i)];
                end
                if ((fwd_addr2 != '0) && (addr_q[rd_ptr_q + PTR_W'(i)] == fwd_addr2)) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = data_q[rd_ptr_q + PTR_W'(i)];
                end
            end
        end
    end
`else
    // No comparators; consumers must resolve hazards by stalling
    logic unused_fwd_addr;
    assign unused_fwd_addr = ^{fwd_addr1, fwd_addr2};
    assign fwd_hit1  = 1'b0;
    assign fwd_hit2  = 1'b0;
    assign fwd_data1 = '0;
    assign fwd_data2 = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Testbench for writeback_queue: directed scenarios plus randomized traffic,
// checked against a queue-based reference model.
module tb_writeback_queue;

    logic        clk = 1'b0;
    logic        rstn;
    logic        in_valid;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        in_ready;
    logic        wb_stall;
    logic        wb_wen;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  fwd_addr1, fwd_addr2;
    logic        fwd_hit1, fwd_hit2;
    logic [31:0] fwd_data1, fwd_data2;
    logic [2:0]  count;

    int vectors = 0;
    int miscompares = 0;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    ent_t mq[$];

    always #5 clk = ~clk;

    writeback_queue dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_ready(in_ready),
        .wb_stall(wb_stall), .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
        .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2),
        .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2),
        .count(count)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Youngest matching entry in the model queue
    task automatic model_fwd(input logic [4:0] a, output logic hit, output logic [31:0] d);
        hit = 1'b0;
        d   = '0;
`ifdef WBQ_FORWARD_EN
        if (a != 5'd0) begin
            for (int k = mq.size() - 1; k >= 0; k--) begin
                if (mq[k].a == a) begin
                    hit = 1'b1;
                    d   = mq[k].d;
                    break;
                end
            end
        end
`endif
    endtask

    // One cycle: drive, check at negedge, advance model at posedge
    task automatic step(input logic v, input logic [4:0] a, input logic [31:0] d,
                        input logic s, input logic [4:0] f1, input logic [4:0] f2);
        logic        e_wen, e_rdy, h;
        logic [4:0]  e_addr;
        logic [31:0] e_data, fd;
        in_valid = v; in_addr = a; in_data = d; wb_stall = s;
        fwd_addr1 = f1; fwd_addr2 = f2;
        @(negedge clk);
        e_wen  = (mq.size() != 0) && !s;
        e_rdy  = (mq.size() < 4) || e_wen;
        e_addr = e_wen ? mq[0].a : 5'd0;
        e_data = e_wen ? mq[0].d : 32'd0;
        chk("count",    64'(count),    64'(mq.size()));
        chk("in_ready", 64'(in_ready), 64'(e_rdy));
        chk("wb_wen",   64'(wb_wen),   64'(e_wen));
        chk("wb_addr",  64'(wb_addr),  64'(e_addr));
        chk("wb_data",  64'(wb_data),  64'(e_data));
        model_fwd(f1, h, fd);
        chk("fwd_hit1",  64'(fwd_hit1),  64'(h));
        chk("fwd_data1", 64'(fwd_data1), 64'(fd));
        model_fwd(f2, h, fd);
        chk("fwd_hit2",  64'(fwd_hit2),  64'(h));
        chk("fwd_data2", 64'(fwd_data2), 64'(fd));
        @(posedge clk);
        if (e_wen) void'(mq.pop_front());
        if (v && e_rdy && a != 5'd0) mq.push_back('{a: a, d: d});
        #1;
    endtask

    initial begin
        rstn = 1'b0;
        in_valid = 1'b0; in_addr = '0; in_data = '0; wb_stall = 1'b0;
        fwd_addr1 = '0; fwd_addr2 = '0;
        #3;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_wen",   64'(wb_wen), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Idle
        step(0, 0, 0, 0, 0, 0);

        // Single write, then its write-back cycle
        step(1, 5'd5, 32'hDEADBEEF, 0, 5, 0);
        chk("single_wen",  64'(wb_wen), 64'd1);
        chk("single_addr", 64'(wb_addr), 64'd5);
        chk("single_data", 64'(wb_data), 64'hDEADBEEF);
        step(0, 0, 0, 0, 5, 0);
        chk("single_cnt", 64'(count), 64'd0);

        // Fill under stall, then drain while accepting x6
        for (int r = 1; r <= 4; r++) step(1, 5'(r), 32'h100 + 32'(r), 1, 5'(r), 3);
        chk("full_cnt",   64'(count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        step(1, 5'd6, 32'h606, 1, 6, 2);
        step(1, 5'd6, 32'h606, 0, 6, 2);
        chk("swap_cnt", 64'(count), 64'd4);
        for (int r = 0; r < 5; r++) step(0, 0, 0, 0, 6, 4);

        // Forwarding priority: youngest of two x7 writes
        step(1, 5'd7, 32'h11, 1, 7, 8);
        step(1, 5'd7, 32'h22, 1, 7, 8);
`ifdef WBQ_FORWARD_EN
        chk("prio_hit1",  64'(fwd_hit1), 64'd1);
        chk("prio_data1", 64'(fwd_data1), 64'h22);
`else
        chk("off_hit1",  64'(fwd_hit1), 64'd0);
        chk("off_data1", 64'(fwd_data1), 64'd0);
`endif
        chk("prio_hit2", 64'(fwd_hit2), 64'd0);
        step(0, 0, 0, 1, 7, 8);
        for (int r = 0; r < 3; r++) step(0, 0, 0, 0, 7, 8);

        // x0 discard
        step(1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
        chk("x0_cnt", 64'(count), 64'd0);
        chk("x0_wen", 64'(wb_wen), 64'd0);
        chk("x0_hit", 64'(fwd_hit1), 64'd0);

        // Asynchronous reset with three entries queued
        for (int r = 0; r < 3; r++) step(1, 5'(9 + r), $urandom, 1, 9, 10);
        in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("arst_cnt",   64'(count), 64'd0);
        chk("arst_wen",   64'(wb_wen), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        chk("arst_hit1",  64'(fwd_hit1), 64'd0);
        mq.delete();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < 3; r++) step(0, 0, 0, 0, 9, 10);

        // Randomized traffic
        for (int r = 0; r < 400; r++) begin
            step(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom,
                 ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
